// File: rtl/trojan_sweep_pkg.sv
// Shared types and constants for the exhaustive vector sweeper.
package trojan_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h002D;

    localparam int REC_N_IN = 7;

    typedef struct packed {
        logic [REC_N_IN-1:0] vec;
        logic                resp;
    } sweep_rec_t;

endpackage

// File: rtl/trojan_vec_sweeper_misr.sv
// Multiple-input signature register: shifts left, folds POLY in on carry-out, XORs in d.
module misr_accum
    import trojan_sweep_pkg::*;
#(
    parameter int                MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY)
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [MISR_W-1:0] d,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_d;
    logic [MISR_W-1:0] sig_q;

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                    input logic [MISR_W-1:0] din);
        logic [MISR_W-1:0] fb;
        fb = s[MISR_W-1] ? POLY : {MISR_W{1'b0}};
        return {s[MISR_W-2:0], 1'b0} ^ fb ^ din;
    endfunction

    // Clear takes priority so a new sweep always starts from the zero seed.
    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = {MISR_W{1'b0}};
        end else if (en) begin
            sig_d = misr_step(sig_q, d);
        end else begin
            sig_d = sig_q;
        end
    end

    // Signature register.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            sig_q <= {MISR_W{1'b0}};
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/trojan_vec_sweeper.sv
// Drives every input vector to a combinational DUT, samples its response after a
// settle interval and streams {vector, response} records while compacting them.
module trojan_vec_sweeper
    import trojan_sweep_pkg::*;
#(
    parameter int                N_IN   = 7,
    parameter int                SETTLE = 1,
    parameter int                MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY)
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [N_IN-1:0]   rec_vec,
    output logic              rec_bit,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature,
    output logic [N_IN:0]     ones_count
);

    localparam int                CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int                OC_W      = N_IN + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]   VEC_LAST  = {N_IN{1'b1}};

    sweep_state_e     state_d, state_q;
    logic [N_IN-1:0]  vec_d, vec_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             rec_valid_d, rec_valid_q;
    logic [N_IN-1:0]  rec_vec_d, rec_vec_q;
    logic             rec_bit_d, rec_bit_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic [OC_W-1:0]  ones_d, ones_q;
    logic             misr_clr_s;
    logic             misr_en_s;
    logic [MISR_W-1:0] misr_in_s;
    logic [MISR_W-1:0] misr_sig_s;

    // Sweep sequencing: settle, capture, hand off, advance or finish.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        rec_valid_d = rec_valid_q;
        rec_vec_d   = rec_vec_q;
        rec_bit_d   = rec_bit_q;
        busy_d      = busy_q;
        done_d      = done_q;
        ones_d      = ones_q;
        misr_clr_s  = 1'b0;
        misr_en_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_APPLY;
                    vec_d      = {N_IN{1'b0}};
                    cnt_d      = {CNT_W{1'b0}};
                    ones_d     = {OC_W{1'b0}};
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    misr_clr_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_APPLY: begin
                if (cnt_q == CNT_LAST) begin
                    rec_bit_d   = dut_out;
                    rec_vec_d   = vec_q;
                    rec_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            ST_EMIT: begin
                // The terminal vector is compared explicitly; vec never wraps.
                if (rec_valid_q && rec_ready) begin
                    misr_en_s   = 1'b1;
                    rec_valid_d = 1'b0;
                    if (rec_bit_q) begin
                        ones_d = ones_q + OC_W'(1'b1);
                    end else begin
                        ones_d = ones_q;
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        vec_d   = vec_q + N_IN'(1'b1);
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_APPLY;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rec_valid_d = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            vec_q       <= {N_IN{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rec_valid_q <= 1'b0;
            rec_vec_q   <= {N_IN{1'b0}};
            rec_bit_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ones_q      <= {OC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            rec_valid_q <= rec_valid_d;
            rec_vec_q   <= rec_vec_d;
            rec_bit_q   <= rec_bit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ones_q      <= ones_d;
        end
    end

    assign misr_in_s = MISR_W'({rec_vec_q, rec_bit_q});

    misr_accum #(
        .MISR_W (MISR_W),
        .POLY   (POLY)
    ) u_misr (
        .CK    (CK),
        .reset (reset),
        .clr   (misr_clr_s),
        .en    (misr_en_s),
        .d     (misr_in_s),
        .sig   (misr_sig_s)
    );

    assign dut_in     = vec_q;
    assign rec_valid  = rec_valid_q;
    assign rec_vec    = rec_vec_q;
    assign rec_bit    = rec_bit_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign signature  = misr_sig_s;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_trojan_vec_sweeper.sv
// Scoreboard bench: expected records queued at start, monitor pops on each handshake.
module tb_trojan_vec_sweeper;
    import trojan_sweep_pkg::*;

    logic CK    = 1'b0;
    logic reset = 1'b0;
    always #5 CK = ~CK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Main instance: defaults (N_IN=7, SETTLE=1, MISR_W=16, POLY=16'h002D)
    logic         start = 1'b0;
    logic [6:0]   dut_in;
    logic         dut_out;
    logic         rec_valid;
    logic         rec_ready = 1'b1;
    logic [6:0]   rec_vec;
    logic         rec_bit;
    logic         busy, done;
    logic [15:0]  signature;
    logic [7:0]   ones_count;
    logic [127:0] tt = 128'h0;

    assign dut_out = tt[dut_in];

    trojan_vec_sweeper u_dut (
        .CK(CK), .reset(reset), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_vec(rec_vec), .rec_bit(rec_bit),
        .busy(busy), .done(done), .signature(signature), .ones_count(ones_count)
    );

    // Golden-signature instance
    logic       start1 = 1'b0;
    logic [1:0] dut_in1, rec_vec1;
    logic       rec_valid1, rec_bit1, busy1, done1;
    logic [7:0] sig1;
    logic [2:0] ones1;

    trojan_vec_sweeper #(.N_IN(2), .SETTLE(1), .MISR_W(8), .POLY(8'h1D)) u_gold (
        .CK(CK), .reset(reset), .start(start1), .dut_in(dut_in1), .dut_out(1'b0),
        .rec_valid(rec_valid1), .rec_ready(1'b1), .rec_vec(rec_vec1), .rec_bit(rec_bit1),
        .busy(busy1), .done(done1), .signature(sig1), .ones_count(ones1)
    );

    // XOR / SETTLE=3 instance
    logic        start3 = 1'b0;
    logic [6:0]  dut_in3, rec_vec3;
    logic        rec_valid3, rec_bit3, busy3, done3;
    logic [15:0] sig3;
    logic [7:0]  ones3;

    trojan_vec_sweeper #(.SETTLE(3)) u_xor (
        .CK(CK), .reset(reset), .start(start3), .dut_in(dut_in3), .dut_out(^dut_in3),
        .rec_valid(rec_valid3), .rec_ready(1'b1), .rec_vec(rec_vec3), .rec_bit(rec_bit3),
        .busy(busy3), .done(done3), .signature(sig3), .ones_count(ones3)
    );

    sweep_rec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference signature: records in order 0..127, d = vec*2 + response.
    function automatic logic [15:0] model_sig(input logic [127:0] t);
        logic [15:0] s;
        logic [15:0] d;
        s = 16'h0000;
        for (int v = 0; v < 128; v++) begin
            d = 16'(v * 2 + int'(t[v]));
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000) ^ d;
        end
        return s;
    endfunction

    // Monitor: every accepted record must match the head of the scoreboard.
    always @(negedge CK) begin
        sweep_rec_t e;
        if (reset && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_record: got vec=0x%0h bit=%0b, expected none", rec_vec, rec_bit);
            end else begin
                e = exp_q.pop_front();
                check("rec_vec", 32'(rec_vec), 32'(e.vec));
                check("rec_bit", 32'(rec_bit), 32'(e.resp));
                check("dut_in_at_accept", 32'(dut_in), 32'(e.vec));
            end
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic push_expected();
        for (int v = 0; v < 128; v++) begin
            exp_q.push_back('{vec: 7'(v), resp: tt[v]});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dut_in"}, 32'(dut_in), 32'd0);
        check({tag, "_rec_valid"}, 32'(rec_valid), 32'd0);
        check({tag, "_rec_vec"}, 32'(rec_vec), 32'd0);
        check({tag, "_rec_bit"}, 32'(rec_bit), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_signature"}, 32'(signature), 32'd0);
        check({tag, "_ones"}, 32'(ones_count), 32'd0);
    endtask

    // Full sweep on the main instance with optional random ready, a 5-cycle
    // stall at stall_vec, and a stray start pulse at restart_vec.
    task automatic run_sweep(input bit rand_ready, input int stall_vec,
                             input int restart_vec, output logic [15:0] sig_out);
        int cyc;
        bit stalled;
        bit restarted;
        push_expected();
        rec_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        check("sig_cleared", 32'(signature), 32'd0);
        check("ones_cleared", 32'(ones_count), 32'd0);
        cyc = 0;
        stalled = 1'b0;
        restarted = 1'b0;
        while (!done && cyc < 3000) begin
            if (stall_vec >= 0 && !stalled && rec_valid && rec_vec == 7'(stall_vec)) begin
                rec_ready = 1'b0;
                repeat (5) begin
                    tick();
                    cyc++;
                    check("stall_valid", 32'(rec_valid), 32'd1);
                    check("stall_rec_vec", 32'(rec_vec), 32'(stall_vec));
                    check("stall_dut_in", 32'(dut_in), 32'(stall_vec));
                end
                stalled = 1'b1;
            end
            if (restart_vec >= 0 && !restarted && dut_in == 7'(restart_vec)) begin
                start = 1'b1;
                restarted = 1'b1;
            end else begin
                start = 1'b0;
            end
            rec_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        start = 1'b0;
        rec_ready = 1'b1;
        check("sweep_timeout", 32'(cyc < 3000), 32'd1);
        if (!rand_ready) begin
            check("sweep_cycles", 32'(cyc), 32'(256 + (stall_vec >= 0 ? 5 : 0)));
        end
        check("done_end", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("last_dut_in", 32'(dut_in), 32'h7F);
        check("ones_count", 32'(ones_count), 32'($countones(tt)));
        check("signature", 32'(signature), 32'(model_sig(tt)));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        sig_out = signature;
    endtask

    initial begin
        int cyc;
        int nrec;
        logic [15:0] s_a, s_b;

        // Reset state
        #12;
        check_all_zero("reset");
        check("gold_reset_sig", 32'(sig1), 32'd0);
        check("xor_reset_busy", 32'(busy3), 32'd0);
        @(negedge CK);
        reset = 1'b1;
        tick();

        // Golden signature, N_IN=2, MISR_W=8, POLY=8'h1D, DUT tied low
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 0;
        nrec = 0;
        while (!done1 && cyc < 100) begin
            if (rec_valid1) begin
                check("gold_rec_vec", 32'(rec_vec1), 32'(nrec));
                check("gold_rec_bit", 32'(rec_bit1), 32'd0);
                nrec++;
            end
            tick();
            cyc++;
        end
        check("gold_records", 32'(nrec), 32'd4);
        check("gold_cycles", 32'(cyc), 32'd8);
        check("gold_signature", 32'(sig1), 32'h06);
        check("gold_ones", 32'(ones1), 32'd0);
        check("gold_busy", 32'(busy1), 32'd0);

        // XOR DUT with SETTLE=3
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        cyc = 0;
        nrec = 0;
        while (!done3 && cyc < 2000) begin
            if (rec_valid3) nrec++;
            tick();
            cyc++;
        end
        check("xor_cycles", 32'(cyc), 32'd512);
        check("xor_busy_at_done", 32'(busy3), 32'd0);
        check("xor_records", 32'(nrec), 32'd128);
        check("xor_ones", 32'(ones3), 32'd64);

        // AND of all inputs
        tt = 128'h0;
        tt[127] = 1'b1;
        run_sweep(1'b0, -1, -1, s_a);

        // Backpressure at vec 3
        tt = {$urandom, $urandom, $urandom, $urandom};
        run_sweep(1'b0, 3, -1, s_a);

        // Randomized truth tables with random ready
        for (int k = 0; k < 2; k++) begin
            tt = {$urandom, $urandom, $urandom, $urandom};
            run_sweep(1'b1, -1, -1, s_a);
        end

        // Asynchronous reset at vec 40
        tt = {$urandom, $urandom, $urandom, $urandom};
        push_expected();
        rec_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (dut_in != 7'd40 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("reach_vec40", 32'(dut_in), 32'd40);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge CK);
        @(negedge CK);
        reset = 1'b1;
        repeat (3) tick();
        check("post_reset_valid", 32'(rec_valid), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        run_sweep(1'b0, -1, -1, s_a);

        // Start pulse while busy at vec 10, then a clean restart
        tt = {$urandom, $urandom, $urandom, $urandom};
        run_sweep(1'b0, -1, 10, s_a);
        run_sweep(1'b0, -1, -1, s_b);
        check("restart_same_sig", 32'(s_b), 32'(s_a));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
